// File: rtl/addsub_op_sequencer.sv
// Handshaked issue/settle/capture sequencer around an external CLA adder-subtractor, with a chaining accumulator.
// Define ADDSUB_SATURATE_EN to saturate captured results on signed overflow; the default build wraps.
module addsub_op_sequencer #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_c,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc_q,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_OUT    = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic             w_clr;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_sub;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_c;
  logic             r_out_ovf;
  logic [WIDTH-1:0] r_acc_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and handshake decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    w_clr        = 1'b0;
    in_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !acc_clr;
        w_clr    = acc_clr;
        w_accept = in_valid && !acc_clr;
        if (w_accept) w_next_state = S_SETTLE;
      end
      S_SETTLE: begin
        w_capture = (r_cnt == CNT_W'(1));
        if (w_capture) w_next_state = S_OUT;
      end
      S_OUT: begin
        w_release = out_ready;
        if (w_release) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

`ifdef ADDSUB_SATURATE_EN
  logic [WIDTH-1:0] w_sat_val;
  // Clamp toward the sign of operand A, which is the sign the true result shares on overflow
  assign w_sat_val = r_add_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_result  = add_ovf ? w_sat_val : add_c;
`else
  assign w_result = add_c;
`endif

  // Operand issue, settle counter, result capture and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_sub   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_c     <= '0;
      r_out_ovf   <= 1'b0;
      r_acc_q     <= '0;
    end else begin
      if (w_clr) r_acc_q <= '0;
      if (w_accept) begin
        r_add_a   <= in_acc ? r_acc_q : in_a;
        r_add_b   <= in_b;
        r_add_sub <= in_sub;
        r_cnt     <= CNT_W'(SETTLE_CYCLES);
      end
      if (r_state == S_SETTLE) r_cnt <= r_cnt - CNT_W'(1);
      if (w_capture) begin
        r_out_c     <= w_result;
        r_out_ovf   <= add_ovf;
        r_acc_q     <= w_result;
        r_out_valid <= 1'b1;
      end
      if (w_release) r_out_valid <= 1'b0;
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_sub   = r_add_sub;
  assign out_valid = r_out_valid;
  assign out_c     = r_out_c;
  assign out_ovf   = r_out_ovf;
  assign acc_q     = r_acc_q;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/addsub_op_sequencer.md
Name: addsub_op_sequencer

Overview:
- Sequencing stage around the 16-bit hybrid CLA adder-subtractor.
- Upstream side: accepts operand/command transactions over a valid/ready handshake, then registers and drives the adder's A, B and SUB inputs.
- Downstream side: waits a programmable settle time, captures the adder's result and overflow, and presents them over a valid/ready output handshake.
- Keeps a running accumulator that can replace operand A, so multi-operand sums and differences can be chained.

Parameters:
- WIDTH, 16, datapath width; must equal the adder width.
- SETTLE_CYCLES, 1, clock edges between operand issue and result capture; legal range 1..15 (multicycle budget for the combinational adder).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accept.
- in_a  in  WIDTH  operand A; ignored when in_acc=1.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A-B.
- in_acc  in  1  1 = use acc_q as operand A.
- acc_clr  in  1  clear accumulator; honoured in IDLE only.
- add_a  out  WIDTH  registered operand A to the adder.
- add_b  out  WIDTH  registered operand B to the adder; un-inverted, the adder applies SUB.
- add_sub  out  1  registered SUB to the adder.
- add_c  in  WIDTH  adder result.
- add_ovf  in  1  adder signed overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_c  out  WIDTH  captured result.
- out_ovf  out  1  captured overflow.
- acc_q  out  WIDTH  accumulator.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, active-high):
  - state = IDLE.
  - add_a, add_b, out_c, acc_q = 0.
  - add_sub, out_ovf, out_valid, busy = 0.
  - Reset mid-operation abandons the operation; no result is emitted.
- States:
  - IDLE:
    - in_ready = !acc_clr.
    - If acc_clr=1: acc_q <= 0; any in_valid that cycle is not accepted.
    - Else on in_valid && in_ready:
      - add_a <= in_acc ? acc_q : in_a.
      - add_b <= in_b.
      - add_sub <= in_sub.
      - cnt <= SETTLE_CYCLES.
      - Go to SETTLE.
  - SETTLE:
    - in_ready = 0.
    - cnt decrements on each edge.
    - On the edge where cnt == 1:
      - out_c <= add_c.
      - out_ovf <= add_ovf.
      - acc_q <= the captured result.
      - out_valid <= 1.
      - Go to OUT.
  - OUT:
    - in_ready = 0.
    - out_valid = 1; out_c and out_ovf are held stable.
    - On out_valid && out_ready: out_valid <= 0, go to IDLE.
- Latency and throughput:
  - Accept at edge t → out_valid high after edge t+SETTLE_CYCLES.
  - Minimum spacing between accepts is SETTLE_CYCLES+2 edges.
  - No overlap of operations.
- add_a, add_b and add_sub change only on an accept edge; they are stable through SETTLE and OUT.
- acc_q updates only at capture or on acc_clr; it always holds the most recent result.
- Arithmetic is modulo 2^WIDTH two's complement.
- out_ovf is per-operation and is not sticky.
- acc_clr and in_acc are ignored outside IDLE.
- Backpressure: out_ready low holds OUT indefinitely; in_valid is not accepted during that time.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- When defined: if add_ovf=1 at capture, out_c and acc_q both take add_a[WIDTH-1] ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}. out_ovf is still 1.
- When undefined: the raw wrapped add_c is captured.

Test Plan:
1. Addition: reset; in_a=0x1234, in_b=0x0101, in_sub=0, SETTLE_CYCLES=1 → out_valid high one edge after accept; out_c=0x1335, out_ovf=0, acc_q=0x1335.
2. Subtraction: in_a=0x0005, in_b=0x0007, in_sub=1 → out_c=0xFFFE, out_ovf=0.
3. Overflow: in_a=0x7FFF, in_b=0x0001, in_sub=0 → out_ovf=1; out_c=0x8000 without the macro, 0x7FFF with ADDSUB_SATURATE_EN. Also in_a=0x8000, in_b=0x0001, in_sub=1 → out_c=0x7FFF without the macro, 0x8000 with it.
4. Accumulate chain: acc_clr pulse, then three ops with in_acc=1, in_b=0x0010, in_sub=0 → out_c = 0x0010, 0x0020, 0x0030; final acc_q=0x0030.
5. Backpressure: out_ready held low 5 cycles with in_valid=1 → out_valid, out_c and add_* stay stable; in_ready=0; no second accept until the edge after out_ready is raised and the FSM returns to IDLE.
6. Reset mid-operation: SETTLE_CYCLES=4, rst asserted 2 cycles after accept → after the next edge out_valid=0, busy=0, in_ready=1, acc_q=0; no result emitted.
